// File: rtl/braun_mult_pipe.sv
// braun_mult_pipe
//   Pipelined Braun array multiplier for the FIR/IIR datapath. Operand b
//   contributes one partial-product row per bit; ROWS_PER_STAGE rows are
//   summed per stage at full A_W+B_W width, with a register after each
//   stage and a final output register. A per-sample mode bit selects
//   unsigned or two's-complement signed arithmetic. A single global
//   advance signal moves every stage at once, so bubbles are kept and a
//   stalled consumer freezes the whole pipe.
//
//   Latency: LAT = B_W / ROWS_PER_STAGE cycles from acceptance to
//   out_valid, plus one cycle per stall.
//
//   Optional feature (macro BRAUN_MULT_PIPE_FLUSH_EN): adds a flush input
//   that clears every valid bit at the next edge and blocks input
//   acceptance while high. Without the macro the pipe clears only on rst.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      (BRAUN_MULT_PIPE_FLUSH_EN only) drop all in-flight samples
//   in_valid   input sample present
//   in_ready   input sample accepted this cycle (= global advance)
//   in_a       multiplicand, A_W bits
//   in_b       multiplier, B_W bits
//   in_signed  1: both operands two's-complement, 0: both unsigned
//   out_valid  out_prod holds a result
//   out_ready  consumer accepts the result
//   out_prod   product, A_W+B_W bits
//   busy       any stage or the output register holds a valid sample
module braun_mult_pipe #(
  parameter int A_W            = 8,
  parameter int B_W            = 8,
  parameter int ROWS_PER_STAGE = 2
) (
  input  logic               clk,
  input  logic               rst,
`ifdef BRAUN_MULT_PIPE_FLUSH_EN
  input  logic               flush,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     in_a,
  input  logic [B_W-1:0]     in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_W+B_W-1:0] out_prod,
  output logic               busy
);

  localparam int P_W = A_W + B_W;
  localparam int LAT = B_W / ROWS_PER_STAGE;

  if (A_W < 2 || B_W < 2 || ROWS_PER_STAGE < 1 || (B_W % ROWS_PER_STAGE) != 0) begin : g_bad_param
    $error("braun_mult_pipe: need A_W>=2, B_W>=2 and B_W a multiple of ROWS_PER_STAGE");
  end

  // Adds one partial-product row to the running sum. In signed mode a is
  // sign-extended and the top row of b carries weight -2^(B_W-1), so it is
  // subtracted; everything wraps modulo 2^P_W, which is exactly the
  // two's-complement product.
  function automatic logic signed [P_W-1:0] add_row(
    input logic signed [P_W-1:0] acc,
    input logic [A_W-1:0]        a,
    input logic                  b_bit,
    input logic                  sgn,
    input int                    r
  );
    logic signed [P_W-1:0] a_ext;
    logic signed [P_W-1:0] term;
    a_ext = {{B_W{sgn & a[A_W-1]}}, a};
    term  = b_bit ? (a_ext <<< r) : '0;
    if (sgn && r == B_W - 1) add_row = acc - term;
    else                     add_row = acc + term;
  endfunction

  logic adv;
  logic clr;

  // Stage registers, index = stage number
  logic signed [P_W-1:0] sum_p [LAT];
  logic [A_W-1:0]        a_p   [LAT];
  logic [B_W-1:0]        b_p   [LAT];
  logic                  sgn_p [LAT];
  logic                  vld_p [LAT];

  // Stage inputs and next-state sums
  logic signed [P_W-1:0] sum_src [LAT];
  logic [A_W-1:0]        a_src   [LAT];
  logic [B_W-1:0]        b_src   [LAT];
  logic                  sgn_src [LAT];
  logic                  vld_src [LAT];
  logic signed [P_W-1:0] sum_nxt [LAT];

  assign adv = !out_valid || out_ready;

`ifdef BRAUN_MULT_PIPE_FLUSH_EN
  assign clr      = flush;
  assign in_ready = adv && !flush;
`else
  assign clr      = 1'b0;
  assign in_ready = adv;
`endif

  always_comb begin
    sum_src[0] = '0;
    a_src[0]   = in_a;
    b_src[0]   = in_b;
    sgn_src[0] = in_signed;
    vld_src[0] = in_valid && in_ready;
    for (int k = 1; k < LAT; k++) begin
      sum_src[k] = sum_p[k-1];
      a_src[k]   = a_p[k-1];
      b_src[k]   = b_p[k-1];
      sgn_src[k] = sgn_p[k-1];
      vld_src[k] = vld_p[k-1];
    end
    for (int k = 0; k < LAT; k++) begin
      sum_nxt[k] = sum_src[k];
      for (int j = 0; j < ROWS_PER_STAGE; j++) begin
        sum_nxt[k] = add_row(sum_nxt[k], a_src[k], b_src[k][k*ROWS_PER_STAGE+j],
                             sgn_src[k], k*ROWS_PER_STAGE+j);
      end
    end
  end

  // ---- stage 0 .. LAT-1 data registers ----
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int k = 0; k < LAT; k++) begin
        sum_p[k] <= sum_nxt[k];
        a_p[k]   <= a_src[k];
        b_p[k]   <= b_src[k];
        sgn_p[k] <= sgn_src[k];
      end
    end
  end

  // ---- stage valids and output register ----
  // out_prod is reset because it must read 0 after reset; a flush only
  // drops valid bits and leaves data untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) vld_p[k] <= 1'b0;
      out_valid <= 1'b0;
      out_prod  <= '0;
    end else begin
      if (adv) begin
        for (int k = 0; k < LAT; k++) vld_p[k] <= vld_src[k];
        out_valid <= vld_p[LAT-1];
        out_prod  <= sum_p[LAT-1];
      end
      if (clr) begin
        for (int k = 0; k < LAT; k++) vld_p[k] <= 1'b0;
        out_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    busy = out_valid;
    for (int k = 0; k < LAT; k++) busy = busy | vld_p[k];
  end

endmodule

// File: doc/braun_mult_pipe.md
Name: braun_mult_pipe

Overview:
- Parametrised, pipelined array multiplier for the FIR/IIR datapath: A_W x B_W operands, full-width product.
- Partial-product rows are summed Braun-style, ROWS_PER_STAGE rows per pipeline stage, with a register after each stage.
- A per-sample mode bit selects unsigned or two's-complement signed arithmetic.
- Valid/ready handshakes on input and output let filter taps stream samples back-to-back and stall under backpressure.

Parameters:
- A_W, 8, width of operand a (>= 2).
- B_W, 8, width of operand b (>= 2); one array row per bit of b.
- ROWS_PER_STAGE, 2, array rows summed between pipeline registers. B_W % ROWS_PER_STAGE must be 0, otherwise elaboration error.
- Derived: LAT = B_W / ROWS_PER_STAGE, pipeline depth in cycles (default 4).

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, asynchronous active-high reset.
- in_valid, in, 1, input sample present.
- in_ready, out, 1, block accepts the input sample this cycle.
- in_a, in, A_W, multiplicand.
- in_b, in, B_W, multiplier.
- in_signed, in, 1, 1 = both operands two's-complement; 0 = both unsigned.
- out_valid, out, 1, out_prod holds a result.
- out_ready, in, 1, consumer accepts the result.
- out_prod, out, A_W+B_W, product.
- busy, out, 1, OR of all stage valid bits.

Behaviour:
- Reset (async assert, released synchronously to clk): all stage valid bits 0; out_valid=0; out_prod=0; busy=0. in_ready=1 as soon as rst deasserts.
- Reset mid-operation: all in-flight samples are discarded. No output appears for them after reset.
- Global advance: adv = !out_valid || out_ready; in_ready = adv. Combinational path out_ready -> in_ready is allowed.
- Input acceptance: the sample is accepted when in_valid && in_ready.
- When adv=1: every stage register loads from the previous stage. Stage 0 loads {in_a, in_b, in_signed, in_valid&&in_ready}; an empty slot is a bubble with valid=0.
- When adv=0: all stage registers, including out_prod and out_valid, hold. Bubbles are not collapsed.
- Latency: a sample accepted at edge N appears with out_valid=1 after edge N+LAT, if no stall occurs in between. Each stall cycle adds 1.
- Throughput: 1 sample/cycle while out_ready=1.
- Stage k (0..LAT-1):
  - adds rows r = k*ROWS_PER_STAGE .. (k+1)*ROWS_PER_STAGE-1;
  - row r = (a AND b[r]) << r;
  - the running sum is carried at full A_W+B_W width, together with a, the remaining bits of b, the mode bit and the valid bit.
- Signed mode:
  - a is sign-extended to A_W+B_W.
  - Row B_W-1 is subtracted (weight -2^(B_W-1)) instead of added.
  - Result is the exact two's-complement product modulo 2^(A_W+B_W).
  - Baugh-Wooley correction terms are acceptable if bit-exact.
- Unsigned mode: exact product, with no overflow possible.
- Mode is tracked per sample: mixed-mode samples may be interleaved in the pipe.
- out_prod changes only when adv=1. Its value is don't-care while out_valid=0, except after reset, when it is 0.
- busy is 1 whenever any stage or the output register holds a valid sample.

Optional Feature:
- Macro: BRAUN_MULT_PIPE_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit).
  - flush=1 at an edge clears every stage valid bit and out_valid. A sample presented that same cycle is not accepted: in_ready=0 while flush=1. Data registers are not cleared.
  - flush overrides stall.
- Undefined: no flush port; the pipe is cleared only by rst.

Test Plan:
- Default params, unsigned mode, out_ready=1; stream 255x255, 0x0F x 0x10, 0x00 x 0xAB on consecutive cycles -> 0xFE01, 0x00F0, 0x0000 on three consecutive cycles, first one 4 cycles after acceptance.
- Signed mode; stream 0x80x0x80, 0xFFx0xFF, 0x80x0x7F, 0x05x0xFD -> 0x4000, 0x0001, 0xC080, 0xFFF1. Interleave with unsigned 0xFFx0xFF -> 0xFE01 and check every sample is bit-exact.
- Backpressure: stream 6 samples, hold out_ready=0 for 3 cycles once out_valid rises -> out_prod/out_valid stable, in_ready=0, no sample lost or duplicated, order preserved.
- Reset mid-operation: 3 samples in flight, pulse rst asynchronously between edges -> out_valid, busy and out_prod are 0 immediately, and no stale result appears afterwards.
- Params A_W=12, B_W=6, ROWS_PER_STAGE=3 (LAT=2): random 1000 samples, both modes, random out_ready -> matches reference model, latency 2 when unstalled.
- With BRAUN_MULT_PIPE_FLUSH_EN: 4 samples in flight, flush=1 for one cycle -> busy=0 next cycle, none of the 4 results are emitted, and the next accepted sample is correct.
